// File: rtl/fifo_pkg.sv
// Shared types and constants for the fifo block and its read-side drain controller.
package fifo_pkg;

  localparam int unsigned FIFO_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } drain_state_t;

endpackage

// File: rtl/fifo_drain_buf.sv
// Circular landing buffer for fifo_drain: tail write on return, head read on
// downstream accept, synchronous clear; head is read straight from storage.
module fifo_drain_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DW    = FIFO_DW,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [DW-1:0]              wdata,
  input  logic                       rd,
  input  logic                       clr,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [DW-1:0]              head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [OW-1:0] count;

  // Wrap explicitly so non-power-of-two depths stay legal.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (rd) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      unique case ({wr, rd})
        2'b10:   count <= count + OW'(1);
        2'b01:   count <= count - OW'(1);
        default: ;
      endcase
    end
  end

  assign occupancy = count;
  assign head      = mem[rd_ptr];

endmodule

// File: rtl/fifo_drain.sv
// Read-side controller for the fifo_if read port: credit-gated pops, latency
// absorption and a valid/ready output stream. Optional word_cnt via FIFO_DRAIN_CNT_EN.
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int unsigned DW        = FIFO_DW,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          flush,
  input  logic          empty,
  input  logic [DW-1:0] rdata,
  output logic          ren,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          busy
`ifdef FIFO_DRAIN_CNT_EN
  ,
  output logic [31:0]   word_cnt
`endif
);

  localparam int unsigned OW = $clog2(BUF_DEPTH + 1);

  if (RD_LAT < 1 || RD_LAT > 2) begin : g_lat_chk
    $error("fifo_drain: RD_LAT must be 1 or 2");
  end
  if (BUF_DEPTH < RD_LAT + 1) begin : g_depth_chk
    $error("fifo_drain: BUF_DEPTH must be >= RD_LAT+1");
  end

  drain_state_t  state_q;
  drain_state_t  state_d;
  logic [RD_LAT-1:0] pipe;
  logic [OW-1:0] occupancy;
  logic [DW-1:0] head;
  int unsigned   inflight;
  int unsigned   used;
  logic          credit_ok;
  logic          ret;
  logic          buf_wr;
  logic          buf_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pipe    <= '0;
    end else begin
      state_q <= state_d;
      pipe    <= RD_LAT'({pipe, ren});
    end
  end

  // Credit counts the issuing pop itself, so every pop has a slot waiting for it.
  always_comb begin
    inflight  = unsigned'($countones(pipe));
    used      = inflight + 32'(occupancy) + 32'd1;
    credit_ok = (used <= BUF_DEPTH);
    ren       = (state_q == RUN) & ~empty & credit_ok & ~flush;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        IDLE:    if (en) state_d = RUN;
        RUN:     if (!en) state_d = DRAIN;
        DRAIN:   begin
          if (en)                 state_d = RUN;
          else if (inflight == 0) state_d = IDLE;
        end
        FLUSH:   if (inflight == 0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign ret    = pipe[RD_LAT-1];
  assign buf_wr = ret & (state_q != FLUSH);
  assign buf_rd = m_valid & m_ready;

  fifo_drain_buf #(
    .DW    (DW),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr        (buf_wr),
    .wdata     (rdata),
    .rd        (buf_rd),
    .clr       (flush),
    .occupancy (occupancy),
    .head      (head)
  );

  assign m_valid = (occupancy != '0);
  assign m_data  = head;
  assign busy    = (state_q != IDLE);

`ifdef FIFO_DRAIN_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt <= '0;
    end else if (flush) begin
      word_cnt <= '0;
    end else if (m_valid & m_ready) begin
      word_cnt <= word_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain: two instances (RD_LAT=1 and RD_LAT=2) each fed
// by a behavioural FIFO; delivered words are compared against the load order.
module tb_fifo_drain;
  import fifo_pkg::*;

  localparam int unsigned DW = 32;

  logic clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  logic rst_tb;

  logic          en_a, flush_a, empty_a, ren_a, m_valid_a, m_ready_a, busy_a;
  logic [DW-1:0] rdata_a, m_data_a;
  logic          en_b, flush_b, empty_b, ren_b, m_valid_b, m_ready_b, busy_b;
  logic [DW-1:0] rdata_b, rdata_b1, m_data_b;
`ifdef FIFO_DRAIN_CNT_EN
  logic [31:0]   word_cnt_a, word_cnt_b;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] src_a [0:16383];
  logic [DW-1:0] src_b [0:16383];
  logic [DW-1:0] out_a [0:16383];
  logic [DW-1:0] out_b [0:16383];
  int n_a = 0, rd_idx_a = 0, out_n_a = 0, ren_err_a = 0;
  int n_b = 0, rd_idx_b = 0, out_n_b = 0, ren_err_b = 0;
  logic hold_empty_a = 1'b0;

  fifo_drain #(.DW(DW), .RD_LAT(1), .BUF_DEPTH(4)) dut_a (
    .clk     (clk_tb),
    .rst     (rst_tb),
    .en      (en_a),
    .flush   (flush_a),
    .empty   (empty_a),
    .rdata   (rdata_a),
    .ren     (ren_a),
    .m_valid (m_valid_a),
    .m_ready (m_ready_a),
    .m_data  (m_data_a),
    .busy    (busy_a)
`ifdef FIFO_DRAIN_CNT_EN
    ,
    .word_cnt(word_cnt_a)
`endif
  );

  fifo_drain #(.DW(DW), .RD_LAT(2), .BUF_DEPTH(4)) dut_b (
    .clk     (clk_tb),
    .rst     (rst_tb),
    .en      (en_b),
    .flush   (flush_b),
    .empty   (empty_b),
    .rdata   (rdata_b),
    .ren     (ren_b),
    .m_valid (m_valid_b),
    .m_ready (m_ready_b),
    .m_data  (m_data_b),
    .busy    (busy_b)
`ifdef FIFO_DRAIN_CNT_EN
    ,
    .word_cnt(word_cnt_b)
`endif
  );

  // Behavioural FIFOs: a pop at edge k presents its word RD_LAT cycles later.
  assign empty_a = (rd_idx_a >= n_a) || hold_empty_a;
  assign empty_b = (rd_idx_b >= n_b);

  always @(posedge clk_tb) begin
    if (ren_a) begin
      if (empty_a) ren_err_a <= ren_err_a + 1;
      rdata_a  <= src_a[rd_idx_a[13:0]];
      rd_idx_a <= rd_idx_a + 1;
    end
  end

  always @(posedge clk_tb) begin
    if (ren_b) begin
      if (empty_b) ren_err_b <= ren_err_b + 1;
      rdata_b1 <= src_b[rd_idx_b[13:0]];
      rd_idx_b <= rd_idx_b + 1;
    end
    rdata_b <= rdata_b1;
  end

  always @(negedge clk_tb) begin
    if (m_valid_a === 1'b1 && m_ready_a === 1'b1 && out_n_a < 16384) begin
      out_a[out_n_a[13:0]] <= m_data_a;
      out_n_a <= out_n_a + 1;
    end
    if (m_valid_b === 1'b1 && m_ready_b === 1'b1 && out_n_b < 16384) begin
      out_b[out_n_b[13:0]] <= m_data_b;
      out_n_b <= out_n_b + 1;
    end
  end

  task automatic tick();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic load_a(input logic [DW-1:0] w);
    src_a[n_a[13:0]] = w;
    n_a++;
  endtask

  task automatic load_b(input logic [DW-1:0] w);
    src_b[n_b[13:0]] = w;
    n_b++;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (ren_a !== 1'b0 || m_valid_a !== 1'b0 || busy_a !== 1'b0 || m_data_a !== '0) begin
      failures++;
      $display("FAIL reset_a ren=%b m_valid=%b busy=%b m_data=%0h required all 0", ren_a, m_valid_a, busy_a, m_data_a);
    end
    checks++;
    if (ren_b !== 1'b0 || m_valid_b !== 1'b0 || busy_b !== 1'b0 || m_data_b !== '0) begin
      failures++;
      $display("FAIL reset_b ren=%b m_valid=%b busy=%b m_data=%0h required all 0", ren_b, m_valid_b, busy_b, m_data_b);
    end
    rst_tb = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) load_a($urandom);
    m_ready_a = 1'b0;
    en_a      = 1'b1;
    repeat (8) tick();
    checks++;
    if (m_valid_a !== 1'b1 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL prereset_active m_valid=%b busy=%b required 1 1", m_valid_a, busy_a);
    end
    #2 rst_tb = 1'b0;
    #1;
    checks++;
    if (ren_a !== 1'b0 || m_valid_a !== 1'b0 || busy_a !== 1'b0 || m_data_a !== '0) begin
      failures++;
      $display("FAIL async_reset ren=%b m_valid=%b busy=%b m_data=%0h required all 0", ren_a, m_valid_a, busy_a, m_data_a);
    end
    en_a = 1'b0;
    tick();
    rst_tb = 1'b1;
    tick();
    checks++;
    if (busy_a !== 1'b0 || m_valid_a !== 1'b0 || ren_a !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle busy=%b m_valid=%b ren=%b required 0 0 0", busy_a, m_valid_a, ren_a);
    end
    n_a = rd_idx_a;
  endtask

  task automatic test_stream();
    logic [DW-1:0] exp3 [3];
    logic [DW-1:0] got  [3];
    int gc [3];
    int c0 = -1;
    int nv = 0;
    exp3 = '{32'd39, 32'd55, 32'd12};
    for (int i = 0; i < 3; i++) begin
      got[i] = 'x;
      gc[i]  = -1;
      load_a(exp3[i]);
    end
    m_ready_a = 1'b1;
    en_a      = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      tick();
      if (ren_a === 1'b1 && c0 < 0) c0 = cyc;
      if (m_valid_a === 1'b1) begin
        if (nv < 3) begin
          got[nv] = m_data_a;
          gc[nv]  = cyc;
        end
        nv++;
      end
    end
    checks++;
    if (c0 < 0) begin
      failures++;
      $display("FAIL stream_ren_seen no ren observed, required at least one");
    end
    checks++;
    if (gc[0] != c0 + 2) begin
      failures++;
      $display("FAIL first_word_latency m_valid at cycle %0d, required %0d", gc[0], c0 + 2);
    end
    checks++;
    if (nv != 3) begin
      failures++;
      $display("FAIL stream_count valid cycles=%0d required 3", nv);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== exp3[i] || gc[i] != gc[0] + i) begin
        failures++;
        $display("FAIL stream_word%0d got=%0d at cycle %0d, required %0d at cycle %0d", i, got[i], gc[i], exp3[i], gc[0] + i);
      end
    end
    en_a = 1'b0;
    repeat (4) tick();
    checks++;
    if (busy_a !== 1'b0) begin
      failures++;
      $display("FAIL stream_idle busy=%b required 0", busy_a);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] words [8];
    int base;
    int pulses = 0;
    int bad    = 0;
    base      = out_n_a;
    m_ready_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      words[i] = $urandom;
      load_a(words[i]);
    end
    en_a = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (ren_a === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 4) begin
      failures++;
      $display("FAIL bp_ren_pulses got=%0d required 4", pulses);
    end
    checks++;
    if (out_n_a != base || m_valid_a !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold delivered=%0d m_valid=%b required 0 and 1", out_n_a - base, m_valid_a);
    end
    m_ready_a = 1'b1;
    repeat (40) tick();
    checks++;
    if (out_n_a - base != 8) begin
      failures++;
      $display("FAIL bp_count delivered=%0d required 8", out_n_a - base);
    end
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = base + i;
      if (out_a[idx[13:0]] !== words[i]) begin
        if (bad == 0) $display("FAIL bp_order word %0d got=%0h required %0h", i, out_a[idx[13:0]], words[i]);
        bad++;
      end
    end
    checks++;
    if (bad != 0) failures++;
    en_a = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_drain();
    logic [DW-1:0] wb [5];
    int t = -1, vc = -1, fall = -1, extra = 0;
    int base;
    base = out_n_b;
    for (int i = 0; i < 5; i++) begin
      wb[i] = $urandom;
      load_b(wb[i]);
    end
    m_ready_b = 1'b1;
    en_b      = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick();
      if (ren_b === 1'b1) begin
        t    = cyc;
        en_b = 1'b0;
        break;
      end
    end
    checks++;
    if (t < 0) begin
      failures++;
      $display("FAIL drain_ren_seen no ren observed, required one");
    end
    for (int cyc = t + 1; cyc < t + 13; cyc++) begin
      tick();
      if (ren_b === 1'b1) extra++;
      if (m_valid_b === 1'b1 && vc < 0) vc = cyc;
      if (busy_b === 1'b0 && fall < 0) fall = cyc;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL drain_no_ren ren pulses after en=0: %0d, required 0", extra);
    end
    checks++;
    if (vc != t + 3) begin
      failures++;
      $display("FAIL drain_latency m_valid at cycle %0d, required %0d", vc, t + 3);
    end
    checks++;
    if (out_n_b - base != 1 || out_b[base[13:0]] !== wb[0]) begin
      failures++;
      $display("FAIL drain_word delivered=%0d first=%0h required 1 word %0h", out_n_b - base, out_b[base[13:0]], wb[0]);
    end
    checks++;
    if (vc < 0 || fall <= vc) begin
      failures++;
      $display("FAIL drain_busy_fall busy fell at cycle %0d, required after m_valid cycle %0d", fall, vc);
    end
    checks++;
    if (ren_err_b != 0) begin
      failures++;
      $display("FAIL ren_while_empty_b count=%0d required 0", ren_err_b);
    end
    n_b = rd_idx_b;
  endtask

  task automatic test_flush();
    int base;
    int pulses = 0;
    base      = out_n_a;
    m_ready_a = 1'b0;
    for (int i = 0; i < 8; i++) load_a($urandom);
    en_a = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (ren_a === 1'b1) pulses++;
      if (pulses == 4) break;
    end
    tick();
    flush_a = 1'b1;
    #1;
    checks++;
    if (ren_a !== 1'b0 || m_valid_a !== 1'b1) begin
      failures++;
      $display("FAIL flush_cycle ren=%b m_valid=%b required 0 1", ren_a, m_valid_a);
    end
    tick();
    flush_a = 1'b0;
    en_a    = 1'b0;
    checks++;
    if (m_valid_a !== 1'b0 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL flush_next m_valid=%b busy=%b required 0 1", m_valid_a, busy_a);
    end
    tick();
    checks++;
    if (busy_a !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle busy=%b required 0", busy_a);
    end
    m_ready_a = 1'b1;
    repeat (5) tick();
    checks++;
    if (out_n_a != base || m_valid_a !== 1'b0) begin
      failures++;
      $display("FAIL flush_dropped delivered=%0d m_valid=%b required 0 0", out_n_a - base, m_valid_a);
    end
`ifdef FIFO_DRAIN_CNT_EN
    checks++;
    if (word_cnt_a !== 32'd0) begin
      failures++;
      $display("FAIL flush_cnt_clear word_cnt=%0d required 0", word_cnt_a);
    end
`endif
    n_a = rd_idx_a;
  endtask

  task automatic test_random();
    localparam int NW = 10000;
    logic [DW-1:0] words [NW];
    logic [DW-1:0] pd;
    logic pv;
    int base, bad = 0, hold_bad = 0;
    base = out_n_a;
    for (int i = 0; i < NW; i++) begin
      words[i] = $urandom;
      load_a(words[i]);
    end
    m_ready_a    = 1'b0;
    hold_empty_a = 1'b0;
    en_a         = 1'b1;
    flush_a      = 1'b1;
    tick();
    flush_a = 1'b0;
    checks++;
    if (ren_a !== 1'b0) begin
      failures++;
      $display("FAIL flush_priority ren=%b required 0 after flush with en=1", ren_a);
    end
`ifdef FIFO_DRAIN_CNT_EN
    checks++;
    if (word_cnt_a !== 32'd0) begin
      failures++;
      $display("FAIL cnt_cleared word_cnt=%0d required 0", word_cnt_a);
    end
`endif
    for (int cyc = 0; cyc < 60000 && (out_n_a - base) < NW; cyc++) begin
      m_ready_a    = ($urandom_range(3) != 0);
      hold_empty_a = ($urandom_range(4) == 0);
      en_a         = ($urandom_range(15) != 0);
      pv = (m_valid_a === 1'b1) && (m_ready_a == 1'b0);
      pd = m_data_a;
      tick();
      if (pv && (m_valid_a !== 1'b1 || m_data_a !== pd)) hold_bad++;
    end
    en_a         = 1'b0;
    hold_empty_a = 1'b0;
    m_ready_a    = 1'b1;
    repeat (6) tick();
    checks++;
    if (out_n_a - base != NW) begin
      failures++;
      $display("FAIL rand_count delivered=%0d required %0d", out_n_a - base, NW);
    end
    for (int i = 0; i < NW; i++) begin
      int idx;
      idx = base + i;
      if (out_a[idx[13:0]] !== words[i]) begin
        if (bad == 0) $display("FAIL rand_order word %0d got=%0h required %0h", i, out_a[idx[13:0]], words[i]);
        bad++;
      end
    end
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (hold_bad != 0) begin
      failures++;
      $display("FAIL rand_hold m_data changed under stall %0d times, required 0", hold_bad);
    end
    checks++;
    if (ren_err_a != 0) begin
      failures++;
      $display("FAIL ren_while_empty_a count=%0d required 0", ren_err_a);
    end
`ifdef FIFO_DRAIN_CNT_EN
    checks++;
    if (word_cnt_a !== 32'(NW)) begin
      failures++;
      $display("FAIL word_cnt got=%0d required %0d", word_cnt_a, NW);
    end
`endif
  endtask

  initial begin
    rst_tb    = 1'b0;
    en_a      = 1'b0;
    flush_a   = 1'b0;
    m_ready_a = 1'b0;
    en_b      = 1'b0;
    flush_b   = 1'b0;
    m_ready_b = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_drain();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
